// File: rtl/knight_anim_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : knight_anim_sequencer
// Purpose  : Knight sprite animation sequencer. It steps IDLE/WALK/ATTACK/HURT
//            frames on VGA frame ticks and produces the sprite ROM base address,
//            the facing direction and the attack hitbox flag.
// Options  : `define ATTACK_BUFFER_EN keeps one attack request that arrives
//            during ATTACK and chains a second ATTACK when the first completes.
// Revision : 1.0 - initial release
// ============================================================================
module knight_anim_sequencer #(
    parameter int HOLD_TICKS = 4,
    parameter int FRAME_PIX  = 1920
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_frame_clk,
    input  logic        i_move_left,
    input  logic        i_move_right,
    input  logic        i_attack_req,
    input  logic        i_hurt_req,
    output logic [1:0]  o_anim_state,
    output logic [2:0]  o_frame_idx,
    output logic [14:0] o_rom_base,
    output logic        o_flip_h,
    output logic        o_attack_active,
    output logic        o_busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WALK   = 2'd1;
    localparam logic [1:0] S_ATTACK = 2'd2;
    localparam logic [1:0] S_HURT   = 2'd3;

    localparam logic [3:0] C_HOLD_LAST = 4'(HOLD_TICKS - 1);

    logic       r_frame_clk_d;
    logic [3:0] r_hold;
    logic       r_attack_pend;
    logic       r_hurt_pend;

    logic       w_tick;
    logic       w_move_valid;
    logic [1:0] w_move_state;
    logic       w_hurt;
    logic       w_attack;
    logic       w_term;
    logic       w_last;
    logic [2:0] w_last_frame;
    logic [1:0] w_next_state;
    logic [2:0] w_next_frame;
    logic [3:0] w_next_hold;
    logic       w_keep_attack;
    logic [3:0] w_next_base;
    logic [3:0] w_abs_frame;
    logic [14:0] w_next_rom;

    assign w_tick       = i_frame_clk & ~r_frame_clk_d;
    assign w_move_valid = i_move_left ^ i_move_right;
    assign w_move_state = w_move_valid ? S_WALK : S_IDLE;
    // Requests raised in the tick cycle itself are honoured on that tick.
    assign w_hurt       = r_hurt_pend | i_hurt_req;
    assign w_attack     = r_attack_pend | i_attack_req;
    assign w_term       = (r_hold == C_HOLD_LAST);
    assign w_last       = (o_frame_idx == w_last_frame);

    // Last frame index of the current state (IDLE/HURT have 2 frames, others 4).
    always_comb begin
        w_last_frame = 3'd1;
        if (o_anim_state == S_WALK || o_anim_state == S_ATTACK) begin
            w_last_frame = 3'd3;
        end
    end

    // Next-state, frame and hold evaluation applied on a tick.
    always_comb begin
        w_next_state  = o_anim_state;
        w_next_frame  = o_frame_idx;
        w_next_hold   = r_hold;
        w_keep_attack = 1'b0;
        if (w_hurt && o_anim_state != S_HURT) begin
            w_next_state = S_HURT;
            w_next_frame = 3'd0;
            w_next_hold  = 4'd0;
        end else if (w_attack && !o_busy) begin
            w_next_state = S_ATTACK;
            w_next_frame = 3'd0;
            w_next_hold  = 4'd0;
        end else if (!o_busy && w_move_state != o_anim_state) begin
            w_next_state = w_move_state;
            w_next_frame = 3'd0;
            w_next_hold  = 4'd0;
        end else if (o_busy && w_term && w_last) begin
            // One-shot animation finished.
            w_next_frame = 3'd0;
            w_next_hold  = 4'd0;
`ifdef ATTACK_BUFFER_EN
            if (o_anim_state == S_ATTACK && w_attack) begin
                w_next_state = S_ATTACK;
            end else begin
                w_next_state = w_move_state;
            end
`else
            w_next_state = w_move_state;
`endif
        end else begin
            if (w_term) begin
                w_next_hold  = 4'd0;
                w_next_frame = w_last ? 3'd0 : o_frame_idx + 3'd1;
            end else begin
                w_next_hold  = r_hold + 4'd1;
            end
`ifdef ATTACK_BUFFER_EN
            w_keep_attack = (o_anim_state == S_ATTACK);
`endif
        end
    end

    // Base frame of the state being entered; feeds the ROM address.
    always_comb begin
        case (w_next_state)
            S_WALK:   w_next_base = 4'd2;
            S_ATTACK: w_next_base = 4'd6;
            S_HURT:   w_next_base = 4'd10;
            default:  w_next_base = 4'd0;
        endcase
    end

    assign w_abs_frame = w_next_base + {1'b0, w_next_frame};
    assign w_next_rom  = 15'(w_abs_frame) * 15'(FRAME_PIX);

    // Edge detector, request latches and all registered outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_frame_clk_d   <= 1'b0;
            r_hold          <= 4'd0;
            r_attack_pend   <= 1'b0;
            r_hurt_pend     <= 1'b0;
            o_anim_state    <= S_IDLE;
            o_frame_idx     <= 3'd0;
            o_rom_base      <= 15'd0;
            o_flip_h        <= 1'b0;
            o_attack_active <= 1'b0;
            o_busy          <= 1'b0;
        end else begin
            r_frame_clk_d <= i_frame_clk;
            if (w_tick) begin
                r_hurt_pend     <= 1'b0;
                r_attack_pend   <= w_keep_attack & w_attack;
                r_hold          <= w_next_hold;
                o_anim_state    <= w_next_state;
                o_frame_idx     <= w_next_frame;
                o_rom_base      <= w_next_rom;
                o_attack_active <= (w_next_state == S_ATTACK) &&
                                   (w_next_frame == 3'd1 || w_next_frame == 3'd2);
                o_busy          <= (w_next_state == S_ATTACK) || (w_next_state == S_HURT);
                // Facing only follows the keys while the knight is free to move.
                if (!o_busy && w_move_valid) begin
                    o_flip_h <= i_move_left;
                end
            end else begin
                r_hurt_pend   <= r_hurt_pend | i_hurt_req;
                r_attack_pend <= r_attack_pend | i_attack_req;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_knight_anim_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_knight_anim_sequencer
// Purpose  : Scoreboard bench for knight_anim_sequencer. A reference model that
//            tracks elapsed ticks per animation pushes the expected outputs of
//            each tick; a monitor pops and compares them on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_knight_anim_sequencer;

    localparam int H  = 4;
    localparam int FP = 1920;
`ifdef ATTACK_BUFFER_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fclk = 1'b0, ml = 1'b0, mr = 1'b0, ar = 1'b0, hr = 1'b0;
    logic [1:0]  st;
    logic [2:0]  fr;
    logic [14:0] rom;
    logic        fl, aa, bz;

    knight_anim_sequencer #(.HOLD_TICKS(H), .FRAME_PIX(FP)) dut (
        .i_clk(clk), .i_reset(rst), .i_frame_clk(fclk),
        .i_move_left(ml), .i_move_right(mr),
        .i_attack_req(ar), .i_hurt_req(hr),
        .o_anim_state(st), .o_frame_idx(fr), .o_rom_base(rom),
        .o_flip_h(fl), .o_attack_active(aa), .o_busy(bz)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  s;
        logic [2:0]  f;
        logic [14:0] r;
        logic        fl;
        logic        aa;
        logic        bz;
    } obs_t;

    obs_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: state plus ticks elapsed since the state was entered.
    int m_s = 0, m_t = 0;
    bit m_flip = 0, m_att = 0, m_hurt = 0;
    int CNT[4]  = '{2, 4, 4, 2};
    int BASE[4] = '{0, 2, 6, 10};

    function automatic obs_t model_out();
        obs_t o;
        int f;
        f = (m_s < 2) ? ((m_t / H) % CNT[m_s]) : (m_t / H);
        o.s  = 2'(m_s);
        o.f  = 3'(f);
        o.r  = 15'((BASE[m_s] + f) * FP);
        o.fl = m_flip;
        o.aa = (m_s == 2) && (f == 1 || f == 2);
        o.bz = (m_s >= 2);
        return o;
    endfunction

    function automatic obs_t dut_out();
        obs_t o;
        o.s = st; o.f = fr; o.r = rom; o.fl = fl; o.aa = aa; o.bz = bz;
        return o;
    endfunction

    task automatic enter(input int s);
        m_s = s;
        m_t = 0;
    endtask

    task automatic model_tick();
        int  tgt;
        int  old;
        bit  keep;
        tgt  = (ml ^ mr) ? 1 : 0;
        old  = m_s;
        keep = 0;
        if (m_hurt && m_s != 3)            enter(3);
        else if (m_att && m_s < 2)         enter(2);
        else if (m_s < 2) begin
            if (tgt != m_s) enter(tgt);
            else            m_t++;
        end else if (m_t + 1 == CNT[m_s] * H) begin
            if (BUF && m_s == 2 && m_att) enter(2);
            else                          enter(tgt);
        end else begin
            m_t++;
            keep = BUF && (m_s == 2);
        end
        if (old < 2) begin
            if (ml && !mr)      m_flip = 1;
            else if (mr && !ml) m_flip = 0;
        end
        m_hurt = 0;
        if (!keep) m_att = 0;
        q.push_back(model_out());
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: one expected record per tick, compared half a cycle later.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            obs_t e;
            e = q.pop_front();
            check("tick_outputs", 32'(dut_out()), 32'(e));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic tick();
        fclk = 1'b1;
        @(posedge clk); #1;
        fclk = 1'b0;
        model_tick();
        cyc(1);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_att();
        ar = 1'b1; @(posedge clk); #1; ar = 1'b0; m_att = 1;
    endtask

    task automatic pulse_hurt();
        hr = 1'b1; @(posedge clk); #1; hr = 1'b0; m_hurt = 1;
    endtask

    // Reset asserted between clock edges must clear outputs before the next edge.
    task automatic mid_reset(input string name);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check(name, 32'(dut_out()), 32'(obs_t'(0)));
        @(posedge clk); #1;
        rst = 1'b0;
        m_s = 0; m_t = 0; m_flip = 0; m_att = 0; m_hurt = 0;
    endtask

    int idle_seq[8] = '{0, 0, 0, 1, 1, 1, 1, 0};

    initial begin
        #2 rst = 1'b1;
        #1 check("reset_state", 32'(dut_out()), 32'(obs_t'(0)));
        cyc(2);
        rst = 1'b0;
        cyc(1);

        // Idle loop frame sequence after reset.
        for (int i = 0; i < 8; i++) begin
            tick();
            check("idle_frame_seq", 32'(fr), 32'(idle_seq[i]));
        end

        // Walk left.
        ml = 1'b1;
        tick();
        check("walk_rom0", 32'(rom), 32'd3840);
        check("walk_flip", 32'(fl), 32'd1);
        ticks(4);
        check("walk_rom1", 32'(rom), 32'd5760);
        ml = 1'b0;
        tick();

        // Single attack.
        pulse_att();
        tick();
        check("attack_rom", 32'(rom), 32'd11520);
        check("attack_busy", 32'(bz), 32'd1);
        ticks(4);
        check("attack_hitbox", 32'(aa), 32'd1);
        ticks(12);
        check("attack_done", 32'(st), 32'd0);

        // Hurt pre-empts attack in frame 2, facing frozen while hurt.
        pulse_att();
        ticks(9);
        pulse_hurt();
        mr = 1'b1;
        tick();
        check("hurt_rom", 32'(rom), 32'd19200);
        check("hurt_hitbox", 32'(aa), 32'd0);
        ticks(8);
        check("hurt_to_walk", 32'(st), 32'd1);
        check("hurt_flip_kept", 32'(fl), 32'd1);
        mr = 1'b0;
        tick();

        // Second attack request while attacking.
        pulse_att();
        ticks(3);
        pulse_att();
        ticks(14);
        check("second_attack", 32'({st, fr}), BUF ? 32'({2'd2, 3'd0}) : 32'({2'd0, 3'd0}));

        // Reset in the middle of HURT.
        pulse_hurt();
        ticks(3);
        mid_reset("reset_mid_hurt");
        ticks(3);

        // Randomised stimulus.
        for (int n = 0; n < 400; n++) begin
            int gap;
            gap = 1 + int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 3) == 0) begin
                    ml = 1'($urandom);
                    mr = 1'($urandom);
                end
                ar = ($urandom_range(0, 7) == 0);
                hr = ($urandom_range(0, 15) == 0);
                @(posedge clk); #1;
                if (ar) m_att = 1;
                if (hr) m_hurt = 1;
                ar = 1'b0;
                hr = 1'b0;
            end
            if ($urandom_range(0, 99) == 0) mid_reset("reset_random");
            tick();
        end

        cyc(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
